seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the hex-to-7-segment encoder. Snoops a multiplexed 7-seg display
//  bus (segments + per-digit anodes), debounces each digit, and decodes its pattern back to a nibble.
//  It assembles the NDIG nibbles into one word. Sits beside the display driver on the FPGA top, so a
//  bench or on-chip checker can read back what the display actually shows.
// PARAMETERS
//  NDIG           4   number of multiplexed digits (word width = 4*NDIG)
//  STABLE_CYCLES  4   consecutive identical samples required before a digit is accepted (>=2)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  seg         in   7        segment lines, active-high, seg[0]=a .. seg[6]=g
//  an_n        in   NDIG     digit enables, active-low; exactly one low = that digit is driven
//  word        out  4*NDIG   decoded word, digit 0 in word[3:0]
//  word_valid  out  1        1-cycle pulse: word/word_err/blank_mask updated
//  word_err    out  1        some digit in the frame carried an undecodable pattern
//  blank_mask  out  NDIG     bit i set: digit i was blank (seg==7'h00) in the frame
// BEHAVIOUR
//  - Reset (async assert, sync release): word=0, word_valid=0, word_err=0, blank_mask=0,
//    FSM=IDLE, stable counter=0, seen mask=0, digit slots=0.
//  - Inputs go through one register stage (seg_q, an_q) before any decision.
//  - Decode table (seg hex -> nibble): 3F-0 06-1 5B-2 4F-3 66-4 6D-5 7D-6 07-7 7F-8 6F-9
//    77-A 7C-b 39-C 5E-d 79-E 71-F; 00 = blank (nibble 0, blank bit); any other = invalid (nibble 0, err bit).
//  - FSM per digit dwell:
//    IDLE   : an_q not one-hot-low -> stay; one-hot-low -> SETTLE, cnt=1.
//    SETTLE : {an_q,seg_q} equal to previous sample -> cnt++; changed -> cnt=1 (stay SETTLE if
//             one-hot-low, else IDLE). cnt==STABLE_CYCLES -> CAPTURE.
//    CAPTURE: one cycle; write nibble/blank/err into slot of the active digit, set seen[i] -> HOLD.
//    HOLD   : no change -> stay (no recapture); any change -> SETTLE (one-hot) or IDLE.
//  - Latency: inputs stable from cycle 0 -> slot written at edge STABLE_CYCLES+2.
//  - Frame: when seen == all ones, next cycle word_valid=1 and word/word_err/blank_mask load from the slots.
//    Slots and seen clear in the same cycle. A CAPTURE in that same cycle belongs to the new frame.
//  - Re-capture of a digit already seen in the current frame overwrites its slot (last value wins).
//  - All anodes high or >1 low: treated as "no digit", never captured, never an error.
//  - word/word_err/blank_mask hold between pulses; word_valid is never high two cycles in a row.
//  - Reset mid-dwell/mid-frame discards the partial frame; no word_valid is emitted for it.
// STRUCTURE
//  - Package seg7_pkg: localparam patterns SEG_0..SEG_F, SEG_BLANK, and typedef/localparams for
//    FSM state encoding (IDLE, SETTLE, CAPTURE, HOLD). This package is shared with the encoder
//    so the two tables never diverge.
//  - Sub-module seg7_pattern_decode (combinational): seg[6:0] -> {nibble[3:0], blank, invalid}.
//  - Top holds the input flops, stable counter ($clog2(STABLE_CYCLES+1) bits), FSM,
//    NDIG slot array, seen mask and frame assembly.
// TESTING
//  1. Reset: assert rst_n=0 mid-simulation with traffic -> all outputs 0 immediately; no word_valid
//     until a full new frame.
//  2. Scan an_n=E,D,B,7 with seg=06,5B,4F,66, each held 8 cycles -> one word_valid pulse;
//     word=16'h4321, word_err=0, blank_mask=0.
//  3. Glitch: digit0 seg=7F for 3 cycles then 6F held (STABLE_CYCLES=4) -> digit0 decodes 9, never 8.
//  4. Invalid/blank: digit1 seg=7'h01, digit2 seg=7'h00, others 3F -> word=16'h0000,
//     word_err=1, blank_mask=4'b0100.
//  5. Illegal anodes: an_n=4'b1100 or 4'hF for 20 cycles -> no capture, no word_valid, no error.
//  6. Overwrite: digit0 shows 1 then 5 before digits 1-3 appear (A,b,C) -> word=16'hCBA5,
//     exactly one word_valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment pattern table and scan-decoder FSM encoding
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_TAB [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: segment pattern back to nibble with blank/invalid flags
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalid
);
  always_comb begin
    nibble = '0;
    blank = seg == SEG_BLANK;
    invalid = !blank;
    for (int i = 0; i < 16; i++)
      if (seg == SEG_TAB[i]) begin
        nibble = 4'(i);
        invalid = 1'b0;
      end
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a multiplexed 7-seg bus and reassembles the displayed word
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   an_n,
  output logic [4*NDIG-1:0] word,
  output logic              word_valid,
  output logic              word_err,
  output logic [NDIG-1:0]   blank_mask
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [6:0] seg_q, seg_p;
  logic [NDIG-1:0] an_q, an_p, act, slot_blank, slot_err, seen;
  logic [4*NDIG-1:0] slot_word;
  logic [CW-1:0] cnt;
  state_t st;
  logic [3:0] nib;
  logic blank, invalid, one_hot, changed, frame;
  assign act = ~an_q;
  assign one_hot = act != '0 && (act & (act - 1'b1)) == '0;
  assign changed = {an_q, seg_q} != {an_p, seg_p};
  assign frame = &seen;
  // the previous sample is the confirmed-stable value while in CAPTURE
  seg7_pattern_decode u_dec (.seg(seg_p), .nibble(nib), .blank(blank), .invalid(invalid));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      seg_p <= '0;
      an_q <= '1;
      an_p <= '1;
      st <= IDLE;
      cnt <= '0;
      seen <= '0;
      slot_word <= '0;
      slot_blank <= '0;
      slot_err <= '0;
      word <= '0;
      word_valid <= 1'b0;
      word_err <= 1'b0;
      blank_mask <= '0;
    end else begin
      seg_q <= seg;
      an_q <= an_n;
      seg_p <= seg_q;
      an_p <= an_q;
      case (st)
        IDLE: if (one_hot) begin
          st <= SETTLE;
          cnt <= CW'(1);
        end
        SETTLE: if (changed) begin
          st <= one_hot ? SETTLE : IDLE;
          cnt <= CW'(1);
        end else begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(STABLE_CYCLES - 1)) st <= CAPTURE;
        end
        default: if (changed) begin
          st <= one_hot ? SETTLE : IDLE;
          cnt <= CW'(1);
        end else st <= HOLD;
      endcase
      word_valid <= frame;
      if (frame) begin
        word <= slot_word;
        word_err <= |slot_err;
        blank_mask <= slot_blank;
        seen <= '0;
        slot_word <= '0;
        slot_blank <= '0;
        slot_err <= '0;
      end
      if (st == CAPTURE)
        for (int i = 0; i < NDIG; i++)
          if (!an_p[i]) begin
            slot_word[4*i+:4] <= nib;
            slot_blank[i] <= blank;
            slot_err[i] <= invalid;
            seen[i] <= 1'b1;
          end
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: randomized scoreboard bench against a dwell-level display model
module tb_seg7_scan_decoder;
  localparam int NDIG = 4;
  localparam int S = 4;
  logic clk = 0, rst_n = 0;
  logic [6:0] seg = '0;
  logic [3:0] an_n = 4'hF;
  logic [15:0] word;
  logic word_valid, word_err;
  logic [3:0] blank_mask;
  seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an_n(an_n),
    .word(word), .word_valid(word_valid), .word_err(word_err), .blank_mask(blank_mask));
  always #5 clk = ~clk;
  typedef struct {logic [15:0] w; logic e; logic [3:0] b; int c;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] last_w = '0;
  logic last_e = 1'b0;
  logic [3:0] last_b = '0;
  logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] m_w;
  logic [3:0] m_e, m_b, m_seen;
  logic [10:0] m_last;
  bit m_have;
  int m_run;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask
  function automatic void model_clear();
    m_w = '0; m_e = '0; m_b = '0; m_seen = '0; m_have = 0; m_run = 0;
    q.delete();
    last_w = '0; last_e = 1'b0; last_b = '0;
  endfunction
  // a one-hot value held for S consecutive samples is captured once; a full set of digits emits a word
  task automatic model_step(input logic [3:0] an, input logic [6:0] s);
    int edge_n, d;
    logic [3:0] act, n;
    bit ok;
    edge_n = cyc + 1; d = 0; act = ~an; n = '0; ok = 0;
    if (m_have && {an, s} == m_last) m_run++; else m_run = 1;
    m_have = 1;
    m_last = {an, s};
    if ($countones(act) == 1 && m_run == S) begin
      for (int i = 0; i < NDIG; i++) if (act[i]) d = i;
      for (int k = 0; k < 16; k++) if (tab[k] == s) begin n = k[3:0]; ok = 1; end
      m_w[4*d+:4] = n;
      m_b[d] = s == 7'h00;
      m_e[d] = !ok && s != 7'h00;
      m_seen[d] = 1'b1;
      if (&m_seen) begin
        q.push_back('{m_w, |m_e, m_b, edge_n + 3});
        m_w = '0; m_e = '0; m_b = '0; m_seen = '0;
      end
    end
  endtask
  task automatic drive(input logic [3:0] an, input logic [6:0] s, input int n);
    repeat (n) begin
      @(negedge clk);
      an_n = an;
      seg = s;
      model_step(an, s);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_clear();
    #1;
    check("reset_outputs", {word, word_err, blank_mask, word_valid}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_step(an_n, seg);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (q.size() > 0 && cyc > q[0].c) begin
        checks++;
        failures++;
        $display("FAIL word_valid_missing actual=0 expected=1 cycle=%0d", q[0].c);
        void'(q.pop_front());
      end
      if (word_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word_valid actual=1 expected=0 cycle=%0d word=%h", cyc, word);
        end else begin
          e = q.pop_front();
          check("valid_cycle", cyc, e.c);
          check("word", word, e.w);
          check("word_err", word_err, e.e);
          check("blank_mask", blank_mask, e.b);
          last_w = e.w; last_e = e.e; last_b = e.b;
        end
      end else check("hold_outputs", {word, word_err, blank_mask}, {last_w, last_e, last_b});
    end
  end
  initial begin
    model_clear();
    do_reset();
    drive(4'hE, 7'h06, 8);
    drive(4'hD, 7'h5B, 3);
    do_reset();
    drive(4'hB, 7'h4F, 8);
    drive(4'h7, 7'h66, 8);
    drive(4'hE, 7'h06, 8);
    drive(4'hD, 7'h5B, 8);
    drive(4'hB, 7'h4F, 8);
    drive(4'h7, 7'h66, 8);
    drive(4'hF, 7'h00, 6);
    drive(4'hE, 7'h7F, 3);
    drive(4'hE, 7'h6F, 8);
    drive(4'hD, 7'h3F, 8);
    drive(4'hB, 7'h3F, 8);
    drive(4'h7, 7'h3F, 8);
    drive(4'hE, 7'h3F, 8);
    drive(4'hD, 7'h01, 8);
    drive(4'hB, 7'h00, 8);
    drive(4'h7, 7'h3F, 8);
    drive(4'hC, 7'h3F, 20);
    drive(4'hF, 7'h06, 20);
    drive(4'hE, 7'h06, 8);
    drive(4'hE, 7'h6D, 8);
    drive(4'hD, 7'h77, 8);
    drive(4'hB, 7'h7C, 8);
    drive(4'h7, 7'h39, 8);
    drive(4'hF, 7'h00, 8);
    for (int f = 0; f < 40; f++)
      for (int d = 0; d < NDIG; d++)
        drive(~(4'b0001 << d), ($urandom_range(0, 9) < 8) ? tab[$urandom_range(0, 15)] : 7'($urandom),
              $urandom_range(3, 8));
    for (int r = 0; r < 300; r++) begin
      logic [3:0] an;
      logic [6:0] s;
      int p;
      p = $urandom_range(0, 99);
      an = (p < 80) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      p = $urandom_range(0, 99);
      s = (p < 70) ? tab[$urandom_range(0, 15)] : (p < 80) ? 7'h00 : 7'($urandom);
      drive(an, s, $urandom_range(1, 9));
      if (r == 150) do_reset();
    end
    drive(4'hF, 7'h00, 10);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
